// File: rtl/hps_reset_pulser_if.sv
`default_nettype none
// ============================================================================
//  Module      : hps_reset_pulser_if
//  Description : Request/pulse bundle for hps_reset_pulser. It carries the
//                asynchronous level requests in and the registered reset
//                request pulses and busy flags out.
//                Optional status signals exist only when
//                HPS_RESET_PULSER_STATUS_EN is defined.
//  Signals     : req_in     [NUM_CH]   level requests, asynchronous to clk
//                pulse_out  [NUM_CH]   active-high reset request pulses
//                busy       [NUM_CH]   channel in PULSE or HOLDOFF
//                any_busy              OR of busy
//                status_clr            (status build) clear sticky/pulse_cnt
//                sticky     [NUM_CH]   (status build) channel has pulsed
//                pulse_cnt  [NUM_CH*8] (status build) saturating pulse counts
//  Modports    : master = request source, slave = hps_reset_pulser
//  Revision    : 1.0  initial release
// ============================================================================
interface hps_reset_pulser_if #(
    parameter int NUM_CH = 3
);
    logic [NUM_CH-1:0]   req_in;
    logic [NUM_CH-1:0]   pulse_out;
    logic [NUM_CH-1:0]   busy;
    logic                any_busy;

`ifdef HPS_RESET_PULSER_STATUS_EN
    logic                status_clr;
    logic [NUM_CH-1:0]   sticky;
    logic [NUM_CH*8-1:0] pulse_cnt;

    modport master (
        output req_in, status_clr,
        input  pulse_out, busy, any_busy, sticky, pulse_cnt
    );
    modport slave (
        input  req_in, status_clr,
        output pulse_out, busy, any_busy, sticky, pulse_cnt
    );
`else
    modport master (
        output req_in,
        input  pulse_out, busy, any_busy
    );
    modport slave (
        input  req_in,
        output pulse_out, busy, any_busy
    );
`endif
endinterface
`default_nettype wire

// File: rtl/hps_reset_pulser.sv
`default_nettype none
// ============================================================================
//  Module      : hps_reset_pulser
//  Description : Multi-channel reset-request pulse generator. Each channel
//                synchronises a level request, detects a configurable edge
//                and emits a stretched active-high pulse followed by a
//                holdoff. Lower channel index has higher priority; a
//                pulsing channel forces all lower channels back to IDLE.
//  Ports       : clk        block clock
//                rst_n      asynchronous active-low reset
//                bus        hps_reset_pulser_if.slave (req_in, pulse_out,
//                           busy, any_busy [, status_clr, sticky, pulse_cnt])
//  Option      : HPS_RESET_PULSER_STATUS_EN adds sticky flags and 8-bit
//                saturating per-channel pulse counters.
//  Revision    : 1.0  initial release
// ============================================================================
module hps_reset_pulser #(
    parameter int                       NUM_CH        = 3,
    parameter int                       CNT_W         = 6,
    parameter int                       SYNC_STAGES   = 2,
    parameter logic [NUM_CH*CNT_W-1:0]  PULSE_LEN_VEC = {6'd32, 6'd2, 6'd6},
    parameter logic [2*NUM_CH-1:0]      EDGE_VEC      = {2'd0, 2'd0, 2'd0},
    parameter logic [NUM_CH-1:0]        RETRIG_VEC    = 3'b000,
    parameter int                       HOLDOFF       = 4
) (
    input  wire logic           clk,
    input  wire logic           rst_n,
    hps_reset_pulser_if.slave   bus
);

    // ------------------------------------------------------------------
    // Elaboration-time parameter checks
    // ------------------------------------------------------------------
    if (NUM_CH < 1 || NUM_CH > 8) begin : g_err_num_ch
        $error("hps_reset_pulser: NUM_CH must be 1..8");
    end
    if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_err_sync
        $error("hps_reset_pulser: SYNC_STAGES must be 2..4");
    end
    if (HOLDOFF < 0 || HOLDOFF > ((1 << CNT_W) - 1)) begin : g_err_holdoff
        $error("hps_reset_pulser: HOLDOFF does not fit in CNT_W bits");
    end

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PULSE = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] c_HOLDOFF = CNT_W'(HOLDOFF);
    localparam logic [2:0]       c_ARM     = 3'(SYNC_STAGES + 1);

    // A zero length field still yields a one-cycle pulse.
    function automatic logic [CNT_W-1:0] f_pulse_len(input int ch);
        logic [CNT_W-1:0] v;
        v = PULSE_LEN_VEC[ch*CNT_W +: CNT_W];
        if (v == '0) v = CNT_W'(1);
        return v;
    endfunction

    logic [NUM_CH-1:0] w_sync_out;
    logic [NUM_CH-1:0] w_det;
    logic [NUM_CH-1:0] r_prev;
    logic [NUM_CH-1:0] r_edge;
    logic [2:0]        r_arm_cnt;
    logic              w_armed;

    // ------------------------------------------------------------------
    // Per-channel synchroniser and edge qualification
    // ------------------------------------------------------------------
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        localparam logic [1:0] c_EDGE = EDGE_VEC[2*i +: 2];
        logic [SYNC_STAGES-1:0] r_sync;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) r_sync <= '0;
            else        r_sync <= {r_sync[SYNC_STAGES-2:0], bus.req_in[i]};
        end

        assign w_sync_out[i] = r_sync[SYNC_STAGES-1];

        // 0 rising, 1 falling, 2 both, 3 channel disabled
        assign w_det[i] = (c_EDGE == 2'd0) ? ( w_sync_out[i] & ~r_prev[i]) :
                          (c_EDGE == 2'd1) ? (~w_sync_out[i] &  r_prev[i]) :
                          (c_EDGE == 2'd2) ? ( w_sync_out[i] ^  r_prev[i]) :
                                             1'b0;
    end

    // The previous-value register clears to 0 on reset, so a request that is
    // already high at release would look like an edge. The arm counter masks
    // detection until the synchroniser and delayed copy hold real samples.
    assign w_armed = (r_arm_cnt == c_ARM);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_arm_cnt <= '0;
            r_prev    <= '0;
            r_edge    <= '0;
        end else begin
            if (!w_armed) r_arm_cnt <= r_arm_cnt + 3'd1;
            r_prev <= w_sync_out;
            r_edge <= w_det & {NUM_CH{w_armed}};
        end
    end

    // ------------------------------------------------------------------
    // Channel FSMs: next-state in priority order, so a channel entering
    // PULSE cuts every lower channel on the same clock edge.
    // ------------------------------------------------------------------
    state_t            r_state     [NUM_CH];
    state_t            w_state_nxt [NUM_CH];
    logic [CNT_W-1:0]  r_cnt       [NUM_CH];
    logic [CNT_W-1:0]  w_cnt_nxt   [NUM_CH];
    logic [NUM_CH-1:0] w_enter;
    logic [NUM_CH-1:0] w_pulse_nxt;
    logic [NUM_CH-1:0] w_busy_nxt;
    logic              w_hi_pulse;
    logic [NUM_CH-1:0] r_pulse;
    logic [NUM_CH-1:0] r_busy;
    logic              r_any_busy;

    always_comb begin
        w_hi_pulse  = 1'b0;
        w_enter     = '0;
        w_pulse_nxt = '0;
        w_busy_nxt  = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            w_state_nxt[i] = r_state[i];
            w_cnt_nxt[i]   = r_cnt[i];
            if (w_hi_pulse) begin
                w_state_nxt[i] = S_IDLE;
                w_cnt_nxt[i]   = '0;
            end else begin
                case (r_state[i])
                    S_IDLE: begin
                        if (r_edge[i]) begin
                            w_state_nxt[i] = S_PULSE;
                            w_cnt_nxt[i]   = f_pulse_len(i);
                            w_enter[i]     = 1'b1;
                        end
                    end
                    S_PULSE: begin
                        if (r_edge[i] && RETRIG_VEC[i]) begin
                            w_cnt_nxt[i] = f_pulse_len(i);
                        end else if (r_cnt[i] <= CNT_W'(1)) begin
                            if (HOLDOFF == 0) begin
                                w_state_nxt[i] = S_IDLE;
                                w_cnt_nxt[i]   = '0;
                            end else begin
                                w_state_nxt[i] = S_HOLD;
                                w_cnt_nxt[i]   = c_HOLDOFF;
                            end
                        end else begin
                            w_cnt_nxt[i] = r_cnt[i] - CNT_W'(1);
                        end
                    end
                    S_HOLD: begin
                        if (r_cnt[i] <= CNT_W'(1)) begin
                            w_state_nxt[i] = S_IDLE;
                            w_cnt_nxt[i]   = '0;
                        end else begin
                            w_cnt_nxt[i] = r_cnt[i] - CNT_W'(1);
                        end
                    end
                    default: begin
                        w_state_nxt[i] = S_IDLE;
                        w_cnt_nxt[i]   = '0;
                    end
                endcase
            end
            w_hi_pulse     = w_hi_pulse | (w_state_nxt[i] == S_PULSE);
            w_pulse_nxt[i] = (w_state_nxt[i] == S_PULSE);
            w_busy_nxt[i]  = (w_state_nxt[i] != S_IDLE);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_state[i] <= S_IDLE;
                r_cnt[i]   <= '0;
            end
            r_pulse    <= '0;
            r_busy     <= '0;
            r_any_busy <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_state[i] <= w_state_nxt[i];
                r_cnt[i]   <= w_cnt_nxt[i];
            end
            r_pulse    <= w_pulse_nxt;
            r_busy     <= w_busy_nxt;
            r_any_busy <= |w_busy_nxt;
        end
    end

    assign bus.pulse_out = r_pulse;
    assign bus.busy      = r_busy;
    assign bus.any_busy  = r_any_busy;

`ifdef HPS_RESET_PULSER_STATUS_EN
    // ------------------------------------------------------------------
    // Status: only IDLE->PULSE counts as an issued pulse (a retrigger
    // reload does not). A set on the same edge as a clear wins.
    // ------------------------------------------------------------------
    logic [NUM_CH-1:0]   r_sticky;
    logic [NUM_CH*8-1:0] r_pulse_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sticky    <= '0;
            r_pulse_cnt <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (w_enter[i]) begin
                    r_sticky[i] <= 1'b1;
                    if (bus.status_clr)
                        r_pulse_cnt[i*8 +: 8] <= 8'd1;
                    else if (r_pulse_cnt[i*8 +: 8] != 8'hFF)
                        r_pulse_cnt[i*8 +: 8] <= r_pulse_cnt[i*8 +: 8] + 8'd1;
                end else if (bus.status_clr) begin
                    r_sticky[i]           <= 1'b0;
                    r_pulse_cnt[i*8 +: 8] <= 8'd0;
                end
            end
        end
    end

    assign bus.sticky    = r_sticky;
    assign bus.pulse_cnt = r_pulse_cnt;
`endif

endmodule
`default_nettype wire
